wifi_uart_ctrl: RTL and testbench
=================================

// Module: wifi_uart_ctrl
// PURPOSE
//  Host-side controller for the WiFi module's 115200-baud UART core on the Super I/O board.
//  Buffers Z80 port writes in a TX FIFO and received bytes in an RX FIFO.
//  Sequences the core's transmit/is_transmitting handshake and exposes a status byte plus IRQ to the S-100 port decode.
// PARAMETERS
//  TX_AW      4   TX FIFO address width (depth 2**TX_AW = 16)
//  RX_AW      4   RX FIFO address width (depth 16)
// PORTS
//  clk            in   1  master clock, 50 MHz, shared with UART core
//  rst_n          in   1  synchronous reset, active-low
//  cpu_wr_stb     in   1  1-cycle pulse: write cpu_wr_data to data port
//  cpu_wr_data    in   8  byte to transmit
//  cpu_rd_stb     in   1  1-cycle pulse: data port read (pops RX head)
//  cpu_rd_data    out  8  RX FIFO head, first-word fall-through
//  cpu_stat_stb   in   1  1-cycle pulse: status read (clears sticky bits)
//  status         out  8  [0]rx_avail [1]tx_not_full [2]tx_empty [3]tx_busy [4]rx_overrun [5]tx_overflow [6]frame_err [7]0
//  irq            out  1  rx_avail | rx_overrun | frame_err
//  uart_transmit  out  1  1-cycle transmit request to core
//  uart_tx_byte   out  8  byte presented with uart_transmit; held until done
//  uart_is_tx     in   1  core is_transmitting
//  uart_received  in   1  core 1-cycle received pulse
//  uart_rx_byte   in   8  core rx_byte, valid while uart_received
//  uart_recv_err  in   1  core 1-cycle recv_error pulse
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): FIFOs empty; all sticky bits 0; FSM T_IDLE; uart_transmit=0; uart_tx_byte=0; cpu_rd_data=0; irq=0; status=8'h06.
//  TX FSM:
//   T_IDLE: if TX FIFO non-empty -> T_LOAD.
//   T_LOAD: uart_tx_byte=head; uart_transmit=1 for exactly this cycle; pop head -> T_WAIT_BUSY.
//   T_WAIT_BUSY: wait for uart_is_tx=1 -> T_WAIT_DONE.
//   T_WAIT_DONE: wait for uart_is_tx=0 -> T_IDLE.
//   Latency: write to empty idle FIFO -> uart_transmit 2 cycles after cpu_wr_stb.
//  tx_busy = (FSM != T_IDLE).
//  TX FIFO full + cpu_wr_stb: byte dropped; tx_overflow<=1.
//  RX FIFO: uart_received pushes uart_rx_byte.
//   Full and no simultaneous pop: byte dropped; rx_overrun<=1.
//   Full with simultaneous pop: both occur, no overrun.
//  cpu_rd_stb on empty RX FIFO: no pointer change; cpu_rd_data=8'h00.
//  uart_recv_err sets frame_err; no push.
//  Sticky bits [6:4]:
//   Cleared on the cycle after cpu_stat_stb; status shows pre-clear value during the strobe.
//   A set event coincident with the clear wins (bit stays 1).
//  Pointers are AW+1 bits with MSB wrap flag: full = MSBs differ & rest equal; empty = equal.
//  Reset mid-frame: FSM aborts to T_IDLE; top level resets the core from the same rst_n (inverted).
// CONFIGURATION
//  WIFI_CTRL_ECHO_EN defined:
//   Adds a 1-entry echo register, loaded on every successful RX push; a set echo reg is overwritten.
//   In T_IDLE, arbiter grants echo reg vs TX FIFO round-robin; last_grant flips per grant; reset favours echo.
//   T_LOAD pops/clears only the granted source.
//  Not defined: echo logic absent; TX FIFO is the sole source.
// STRUCTURE
//  wifi_ctrl_defs.vh: FSM state encodings (T_IDLE=0..T_WAIT_DONE=3), status bit indices, sticky mask 8'h70.
//  Sub-module wifi_sync_fifo #(W=8,AW): push/pop/full/empty/head, FWFT; instantiated twice (tx, rx).
// TESTING
//  1 Reset, then write 8'h41 -> uart_transmit pulses once 2 cycles later with uart_tx_byte=8'h41; tx_busy until uart_is_tx falls.
//  2 17 writes with core stalled (uart_is_tx=1) -> first popped, 16 buffered, none lost; 18th write sets tx_overflow; all 16 later sent in order.
//  3 17 uart_received pulses 8'h00..8'h10 with no reads -> 16 stored, rx_overrun=1, irq=1.
//   Reads then return 8'h00..8'h0F; status read clears bit 4.
//  4 RX full, uart_received and cpu_rd_stb same cycle -> no overrun, count stays 16.
//   uart_recv_err coincident with cpu_stat_stb -> frame_err remains 1.
//  5 rst_n low during T_WAIT_DONE with 3 bytes queued -> next cycle FSM idle, FIFOs empty, status=8'h06.
//  6 (ECHO_EN) RX 8'h55 while TX FIFO holds 8'hAA -> transmits 8'h55 then 8'hAA; alternation holds under continuous load.

Source files
------------

// File: rtl/wifi_uart_ctrl_pkg.sv
// Shared definitions for the WiFi UART host controller: TX FSM state encoding,
// status byte bit positions and the sticky-bit mask.
package wifi_uart_ctrl_pkg;

  typedef enum logic [1:0] {
    TIdle     = 2'd0,
    TLoad     = 2'd1,
    TWaitBusy = 2'd2,
    TWaitDone = 2'd3
  } tx_state_e;

  localparam int unsigned StRxAvail    = 0;
  localparam int unsigned StTxNotFull  = 1;
  localparam int unsigned StTxEmpty    = 2;
  localparam int unsigned StTxBusy     = 3;
  localparam int unsigned StRxOverrun  = 4;
  localparam int unsigned StTxOverflow = 5;
  localparam int unsigned StFrameErr   = 6;

  // Sticky bits occupy status[6:4]
  localparam logic [7:0] StickyMask = 8'h70;

  // sticky = {frame_err, tx_overflow, rx_overrun}
  function automatic logic [7:0] pack_status(input logic       rx_avail,
                                             input logic       tx_not_full,
                                             input logic       tx_empty,
                                             input logic       tx_busy,
                                             input logic [2:0] sticky);
    logic [7:0] s;
    s                = 8'h00;
    s[StRxAvail]     = rx_avail;
    s[StTxNotFull]   = tx_not_full;
    s[StTxEmpty]     = tx_empty;
    s[StTxBusy]      = tx_busy;
    s[StRxOverrun]   = sticky[0];
    s[StTxOverflow]  = sticky[1];
    s[StFrameErr]    = sticky[2];
    return s;
  endfunction

endpackage

// File: rtl/wifi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry an extra wrap bit so
// full and empty are distinguished without a counter. Head reads as zero when empty.
module wifi_sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [W-1:0] mem_q [Depth];
  logic         do_push, do_pop;

  // Flags, accepted push/pop and next pointers; a push into a full FIFO is
  // accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = do_push ? wptr_q + PtrOne : wptr_q;
    rptr_d  = do_pop ? rptr_q + PtrOne : rptr_q;
    head    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  // Pointer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents need no reset since head is masked when empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/wifi_uart_ctrl.sv
// Host-side controller for the WiFi module's UART core: TX/RX FIFOs, transmit
// handshake FSM, status byte and IRQ. Optional feature macro WIFI_CTRL_ECHO_EN
// adds a one-entry echo register that shares the transmitter with the TX FIFO
// under round-robin arbitration. The UART core itself is reset from the same rst_n.
module wifi_uart_ctrl
  import wifi_uart_ctrl_pkg::*;
#(
  parameter int unsigned TX_AW = 4,
  parameter int unsigned RX_AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_wr_stb,
  input  logic [7:0] cpu_wr_data,
  input  logic       cpu_rd_stb,
  output logic [7:0] cpu_rd_data,
  input  logic       cpu_stat_stb,
  output logic [7:0] status,
  output logic       irq,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_is_tx,
  input  logic       uart_received,
  input  logic [7:0] uart_rx_byte,
  input  logic       uart_recv_err
);

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_pop_ok, rx_push_ok;

  tx_state_e  state_q, state_d;
  logic       transmit_q, transmit_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [2:0] sticky_q, sticky_d, sticky_set;

`ifdef WIFI_CTRL_ECHO_EN
  logic       echo_valid_q, echo_valid_d;
  logic [7:0] echo_byte_q, echo_byte_d;
  logic       grant_echo_q, grant_echo_d;
  logic       last_echo_q, last_echo_d;
`endif

  // FIFO-side handshakes: full TX writes are dropped, RX pops only when data present
  always_comb begin
    tx_push    = cpu_wr_stb && !tx_full;
    rx_pop_ok  = cpu_rd_stb && !rx_empty;
    rx_push_ok = uart_received && (!rx_full || rx_pop_ok);
`ifdef WIFI_CTRL_ECHO_EN
    tx_pop     = (state_q == TLoad) && !grant_echo_q;
`else
    tx_pop     = (state_q == TLoad);
`endif
  end

  wifi_sync_fifo #(
    .W  (8),
    .AW (TX_AW)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (cpu_wr_data),
    .pop   (tx_pop),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  wifi_sync_fifo #(
    .W  (8),
    .AW (RX_AW)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (uart_received),
    .wdata (uart_rx_byte),
    .pop   (cpu_rd_stb),
    .head  (cpu_rd_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // TX FSM next state; uart_transmit is registered so it is high exactly in TLoad
  always_comb begin
    state_d    = state_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
`ifdef WIFI_CTRL_ECHO_EN
    grant_echo_d = grant_echo_q;
    last_echo_d  = last_echo_q;
`endif
    unique case (state_q)
      TIdle: begin
`ifdef WIFI_CTRL_ECHO_EN
        // Echo wins when it is the only source or when the FIFO was granted last
        if (echo_valid_q && (tx_empty || !last_echo_q)) begin
          state_d      = TLoad;
          transmit_d   = 1'b1;
          tx_byte_d    = echo_byte_q;
          grant_echo_d = 1'b1;
          last_echo_d  = 1'b1;
        end else if (!tx_empty) begin
          state_d      = TLoad;
          transmit_d   = 1'b1;
          tx_byte_d    = tx_head;
          grant_echo_d = 1'b0;
          last_echo_d  = 1'b0;
        end
`else
        if (!tx_empty) begin
          state_d    = TLoad;
          transmit_d = 1'b1;
          tx_byte_d  = tx_head;
        end
`endif
      end
      TLoad:     state_d = TWaitBusy;
      TWaitBusy: if (uart_is_tx) state_d = TWaitDone;
      TWaitDone: if (!uart_is_tx) state_d = TIdle;
      default:   state_d = TIdle;
    endcase
  end

  // TX FSM and its registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= TIdle;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
`ifdef WIFI_CTRL_ECHO_EN
      grant_echo_q <= 1'b0;
      last_echo_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
`ifdef WIFI_CTRL_ECHO_EN
      grant_echo_q <= grant_echo_d;
      last_echo_q  <= last_echo_d;
`endif
    end
  end

  // Sticky error bits: a status read clears them next cycle, but a new event wins
  always_comb begin
    sticky_set = {uart_recv_err,
                  cpu_wr_stb && tx_full,
                  uart_received && rx_full && !rx_pop_ok};
    sticky_d   = (cpu_stat_stb ? (sticky_q & ~StickyMask[6:4]) : sticky_q) | sticky_set;
`ifdef WIFI_CTRL_ECHO_EN
    // A fresh RX byte overwrites the echo slot even if it is still pending
    echo_valid_d = (echo_valid_q && !((state_q == TLoad) && grant_echo_q)) || rx_push_ok;
    echo_byte_d  = rx_push_ok ? uart_rx_byte : echo_byte_q;
`endif
  end

  // Sticky bits and echo register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 3'b000;
`ifdef WIFI_CTRL_ECHO_EN
      echo_valid_q <= 1'b0;
      echo_byte_q  <= 8'h00;
`endif
    end else begin
      sticky_q <= sticky_d;
`ifdef WIFI_CTRL_ECHO_EN
      echo_valid_q <= echo_valid_d;
      echo_byte_q  <= echo_byte_d;
`endif
    end
  end

  // Host-visible outputs decoded from registered state
  always_comb begin
    status        = pack_status(!rx_empty, !tx_full, tx_empty, state_q != TIdle, sticky_q);
    irq           = !rx_empty || sticky_q[0] || sticky_q[2];
    uart_transmit = transmit_q;
    uart_tx_byte  = tx_byte_q;
  end

endmodule

// File: tb/tb_wifi_uart_ctrl.sv
// Self-checking bench for wifi_uart_ctrl: directed scenarios plus randomized
// traffic checked against a queue-based model of the FIFOs and sticky bits.
module tb_wifi_uart_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_wr_stb, cpu_rd_stb, cpu_stat_stb;
  logic [7:0] cpu_wr_data, cpu_rd_data, status;
  logic       irq, uart_transmit, uart_is_tx, uart_received, uart_recv_err;
  logic [7:0] uart_tx_byte, uart_rx_byte;

  always #5 clk = ~clk;

  wifi_uart_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_wr_stb    (cpu_wr_stb),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_rd_stb    (cpu_rd_stb),
    .cpu_rd_data   (cpu_rd_data),
    .cpu_stat_stb  (cpu_stat_stb),
    .status        (status),
    .irq           (irq),
    .uart_transmit (uart_transmit),
    .uart_tx_byte  (uart_tx_byte),
    .uart_is_tx    (uart_is_tx),
    .uart_received (uart_received),
    .uart_rx_byte  (uart_rx_byte),
    .uart_recv_err (uart_recv_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte queues for both FIFOs, sticky = {frame, overflow, overrun}
  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];
  logic [7:0] sent_log[$];
  logic [2:0] sticky;
  bit         popped;
  int         tx_total;

  // Behavioural UART core
  bit stall, pending, echo_mode;
  int busy_left, busy_len;

  // Outputs sampled in the most recent cycle
  logic       s_transmit, s_irq;
  logic [7:0] s_txb, s_status, s_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_status_nobusy();
    return {1'b0, sticky[2], sticky[1], sticky[0], 1'b0,
            exp_tx.size() == 0, exp_tx.size() < 16, rx_q.size() > 0};
  endfunction

  task automatic clear_strobes();
    cpu_wr_stb    = 1'b0;
    cpu_rd_stb    = 1'b0;
    cpu_stat_stb  = 1'b0;
    uart_received = 1'b0;
    uart_recv_err = 1'b0;
  endtask

  // One clock cycle: check outputs at negedge, advance the model at posedge
  task automatic tick();
    bit         rd_ok, rx_full, tx_full;
    logic [7:0] mask;
    @(negedge clk);
    s_transmit = uart_transmit;
    s_txb      = uart_tx_byte;
    s_status   = status;
    s_rd       = cpu_rd_data;
    s_irq      = irq;
    mask = echo_mode ? 8'hF1 : 8'hF7;
    check_eq("status", status & mask, exp_status_nobusy() & mask);
    check_eq("rd_data", cpu_rd_data, rx_q.size() > 0 ? rx_q[0] : 8'h00);
    check_eq("irq", irq, (rx_q.size() > 0) || sticky[0] || sticky[2]);
    popped = 1'b0;
    if (uart_transmit) begin
      tx_total++;
      pending = 1'b1;
      sent_log.push_back(uart_tx_byte);
      if (!echo_mode) begin
        if (exp_tx.size() == 0) check_eq("tx_spurious", uart_transmit, 1'b0);
        else begin
          check_eq("tx_byte", uart_tx_byte, exp_tx.pop_front());
          popped = 1'b1;
        end
      end
    end
    @(posedge clk);
    rd_ok   = cpu_rd_stb && rx_q.size() > 0;
    rx_full = rx_q.size() == 16;
    tx_full = (exp_tx.size() + int'(popped)) == 16;
    if (cpu_stat_stb) sticky = 3'b000;
    sticky |= {uart_recv_err, cpu_wr_stb && tx_full, uart_received && rx_full && !cpu_rd_stb};
    if (rd_ok) void'(rx_q.pop_front());
    if (uart_received && (!rx_full || rd_ok)) rx_q.push_back(uart_rx_byte);
    if (cpu_wr_stb && !tx_full) exp_tx.push_back(cpu_wr_data);
    #1;
    clear_strobes();
    if (stall) begin
      uart_is_tx = 1'b1;
      pending    = 1'b0;
      busy_left  = 0;
    end else if (pending) begin
      uart_is_tx = 1'b1;
      busy_left  = busy_len > 0 ? busy_len : int'($urandom_range(1, 4));
      pending    = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) uart_is_tx = 1'b0;
    end else begin
      uart_is_tx = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_strobes();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_tx.delete();
    rx_q.delete();
    sticky    = 3'b000;
    pending   = 1'b0;
    busy_left = 0;
    if (!stall) uart_is_tx = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    cpu_wr_stb  = 1'b1;
    cpu_wr_data = b;
    tick();
  endtask

  task automatic recv_byte(input logic [7:0] b);
    uart_received = 1'b1;
    uart_rx_byte  = b;
    tick();
  endtask

  initial begin
    int t0;
    clear_strobes();
    cpu_wr_data  = 8'h00;
    uart_rx_byte = 8'h00;
    uart_is_tx   = 1'b0;
    stall = 1'b0; pending = 1'b0; echo_mode = 1'b0;
    busy_left = 0; busy_len = 3; tx_total = 0; sticky = 3'b000;

    // 1: reset state, then a single byte and its handshake timing
    do_reset();
    tick();
    check_eq("rst_status", s_status, 8'h06);
    check_eq("rst_rd_data", s_rd, 8'h00);
    check_eq("rst_irq", s_irq, 1'b0);
    check_eq("rst_transmit", s_transmit, 1'b0);
    check_eq("rst_tx_byte", s_txb, 8'h00);
    write_byte(8'h41);
    check_eq("t1_lat0", s_transmit, 1'b0);
    tick();
    check_eq("t1_lat1", s_transmit, 1'b0);
    tick();
    check_eq("t1_pulse", s_transmit, 1'b1);
    check_eq("t1_byte", s_txb, 8'h41);
    check_eq("t1_busy_load", s_status[3], 1'b1);
    tick();
    check_eq("t1_single_pulse", s_transmit, 1'b0);
    check_eq("t1_busy_wait", s_status[3], 1'b1);
    repeat (3) tick();
    check_eq("t1_busy_until_fall", s_status[3], 1'b1);
    tick();
    check_eq("t1_idle", s_status[3], 1'b0);
    check_eq("t1_tx_byte_held", s_txb, 8'h41);

    // 2: core stalled, 18 writes: one in flight, 16 buffered, last dropped
    stall = 1'b1;
    tick();
    t0 = tx_total;
    for (int i = 0; i < 18; i++) write_byte(8'($urandom));
    tick();
    check_eq("t2_overflow", s_status[5], 1'b1);
    check_eq("t2_full", s_status[1], 1'b0);
    check_eq("t2_one_sent", tx_total - t0, 1);
    stall = 1'b0;
    for (int i = 0; i < 400 && exp_tx.size() > 0; i++) tick();
    check_eq("t2_drain", exp_tx.size(), 0);
    check_eq("t2_sent_all", tx_total - t0, 17);
    repeat (10) tick();
    cpu_stat_stb = 1'b1;
    tick();
    check_eq("t2_stat_pre", s_status[5], 1'b1);
    tick();
    check_eq("t2_stat_clr", s_status[5], 1'b0);

    // 3: RX overrun, FIFO order, sticky clear
    for (int i = 0; i < 17; i++) recv_byte(8'(i));
    tick();
    check_eq("t3_overrun", s_status[4], 1'b1);
    check_eq("t3_irq", s_irq, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cpu_rd_stb = 1'b1;
      tick();
      check_eq("t3_rd", s_rd, i);
    end
    tick();
    check_eq("t3_empty", s_status[0], 1'b0);
    cpu_stat_stb = 1'b1;
    tick();
    check_eq("t3_stat_pre", s_status[4], 1'b1);
    tick();
    check_eq("t3_stat_clr", s_status[4], 1'b0);
    check_eq("t3_irq_clr", s_irq, 1'b0);

    // 4: push+pop on full RX, then frame error racing a status read
    for (int i = 0; i < 16; i++) recv_byte(8'h80 + 8'(i));
    uart_received = 1'b1;
    uart_rx_byte  = 8'hC0;
    cpu_rd_stb    = 1'b1;
    tick();
    tick();
    check_eq("t4_no_overrun", s_status[4], 1'b0);
    uart_recv_err = 1'b1;
    cpu_stat_stb  = 1'b1;
    tick();
    tick();
    check_eq("t4_frame_kept", s_status[6], 1'b1);
    for (int i = 0; i < 16; i++) begin
      cpu_rd_stb = 1'b1;
      tick();
      check_eq("t4_rd", s_rd, i < 15 ? 8'h81 + 8'(i) : 8'hC0);
    end
    tick();
    check_eq("t4_count16", s_status[0], 1'b0);
    cpu_stat_stb = 1'b1;
    tick();
    tick();

`ifndef WIFI_CTRL_ECHO_EN
    // Randomized traffic against the model
    busy_len = 0;
    repeat (3000) begin
      cpu_wr_stb    = ($urandom % 4) == 0;
      cpu_wr_data   = 8'($urandom);
      uart_received = ($urandom % 3) == 0;
      uart_rx_byte  = 8'($urandom);
      cpu_rd_stb    = ($urandom % 3) == 0;
      cpu_stat_stb  = ($urandom % 16) == 0;
      uart_recv_err = ($urandom % 64) == 0;
      tick();
    end
    repeat (80) tick();
    check_eq("rnd_drain", exp_tx.size(), 0);
`endif

    // 5: reset in TWaitDone with 3 bytes still queued
    busy_len = 3;
    stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) write_byte(8'hD0 + 8'(i));
    tick();
    tick();
    check_eq("t5_busy", s_status[3], 1'b1);
    check_eq("t5_queued", exp_tx.size(), 3);
    do_reset();
    tick();
    check_eq("t5_status", s_status, 8'h06);
    check_eq("t5_rd_data", s_rd, 8'h00);
    check_eq("t5_irq", s_irq, 1'b0);
    check_eq("t5_transmit", s_transmit, 1'b0);
    check_eq("t5_tx_byte", s_txb, 8'h00);
    stall = 1'b0;
    repeat (5) tick();

`ifdef WIFI_CTRL_ECHO_EN
    // 6: echo register alternates with the TX FIFO, echo first after reset
    echo_mode = 1'b1;
    busy_len  = 2;
    do_reset();
    tick();
    sent_log.delete();
    cpu_wr_stb = 1'b1; cpu_wr_data = 8'hAA;
    uart_received = 1'b1; uart_rx_byte = 8'h55;
    tick();
    tick();
    tick();
    cpu_wr_stb = 1'b1; cpu_wr_data = 8'hAB;
    uart_received = 1'b1; uart_rx_byte = 8'h56;
    tick();
    repeat (40) tick();
    check_eq("t6_count", sent_log.size(), 4);
    if (sent_log.size() == 4) begin
      check_eq("t6_b0", sent_log[0], 8'h55);
      check_eq("t6_b1", sent_log[1], 8'hAA);
      check_eq("t6_b2", sent_log[2], 8'h56);
      check_eq("t6_b3", sent_log[3], 8'hAB);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
